// File: rtl/sr_regdump_tx_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sr_regdump_tx_if : register-dump request, sr_cpu debug port and UART line
// Revision: 1.0
// ----------------------------------------------------------------------------
interface sr_regdump_tx_if;
  logic        start;
  logic [4:0]  regAddr;
  logic [31:0] regData;
  logic        tx;
  logic        busy;
  logic        done;

  // master: the dump engine; slave: board glue / CPU debug port / host side
  modport master (
    input  start,
    input  regData,
    output regAddr,
    output tx,
    output busy,
    output done
  );

  modport slave (
    output start,
    output regData,
    input  regAddr,
    input  tx,
    input  busy,
    input  done
  );
endinterface
`default_nettype wire

// File: rtl/sr_regdump_tx.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sr_regdump_tx : walks sr_cpu registers x0..x(NUM_REGS-1) and sends each one
//                 MSB byte first over a UART 8N1 line
// Revision: 1.0
// ----------------------------------------------------------------------------
module sr_regdump_tx #(
  parameter int CLK_DIV  = 434,
  parameter int NUM_REGS = 32
) (
  input  logic          clk,
  input  logic          rst,
  sr_regdump_tx_if.master bus
);

  localparam logic [15:0] C_RELOAD   = 16'(CLK_DIV - 1);
  localparam logic [4:0]  C_LAST_REG = 5'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_START = 3'd2,
    S_DATA  = 3'd3,
    S_STOP  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [31:0] shreg_q, shreg_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [4:0]  reg_addr_q, reg_addr_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        tick;

  assign tick = (timer_q == 16'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      timer_q    <= 16'd0;
      shreg_q    <= 32'd0;
      byte_idx_q <= 2'd0;
      bit_idx_q  <= 3'd0;
      reg_addr_q <= 5'd0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      shreg_q    <= shreg_d;
      byte_idx_q <= byte_idx_d;
      bit_idx_q  <= bit_idx_d;
      reg_addr_q <= reg_addr_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // tx is registered from the current state, so the line trails the FSM by
  // one cycle; every level still lasts exactly CLK_DIV cycles.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    shreg_d    = shreg_q;
    byte_idx_d = byte_idx_q;
    bit_idx_d  = bit_idx_q;
    reg_addr_d = reg_addr_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    tx_d       = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          busy_d     = 1'b1;
          reg_addr_d = 5'd0;
          state_d    = S_ADDR;
        end
      end
      S_ADDR: begin
        shreg_d    = bus.regData;
        byte_idx_d = 2'd0;
        timer_d    = C_RELOAD;
        state_d    = S_START;
      end
      S_START: begin
        tx_d = 1'b0;
        if (tick) begin
          timer_d   = C_RELOAD;
          bit_idx_d = 3'd0;
          state_d   = S_DATA;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      S_DATA: begin
        // byte 0 is shreg[31:24]; inverting the byte index selects it MSB-first
        tx_d = shreg_q[{~byte_idx_q, bit_idx_q}];
        if (tick) begin
          timer_d = C_RELOAD;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      S_STOP: begin
        if (tick) begin
          timer_d = C_RELOAD;
          if (byte_idx_q != 2'd3) begin
            byte_idx_d = byte_idx_q + 2'd1;
            state_d    = S_START;
          end else if (reg_addr_q < C_LAST_REG) begin
            reg_addr_d = reg_addr_q + 5'd1;
            state_d    = S_ADDR;
          end else begin
            reg_addr_d = 5'd0;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            state_d    = S_IDLE;
          end
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.regAddr = reg_addr_q;
  assign bus.tx      = tx_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_sr_regdump_tx.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_sr_regdump_tx : three sr_regdump_tx instances (single reg /4, single reg
//                    /5, full 32-reg /2) with a UART receiver per instance
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_sr_regdump_tx;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sr_regdump_tx_if bus_a ();
  sr_regdump_tx_if bus_b ();
  sr_regdump_tx_if bus_c ();

  sr_regdump_tx #(.CLK_DIV(4), .NUM_REGS(1)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.master)
  );
  sr_regdump_tx #(.CLK_DIV(5), .NUM_REGS(1)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.master)
  );
  sr_regdump_tx #(.CLK_DIV(2), .NUM_REGS(32)) u_dut_c (
    .clk (clk),
    .rst (rst),
    .bus (bus_c.master)
  );

  // CPU model for the full dump: register n holds 0x01010101*n
  assign bus_c.regData = {4{3'b000, bus_c.regAddr}};

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] q_a[$];
  logic [7:0] q_b[$];
  logic [7:0] q_c[$];

  typedef struct {
    logic [31:0] data;
    logic [7:0]  e0, e1, e2, e3;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic get_tx(input int sel);
    case (sel)
      0:       return bus_a.tx;
      1:       return bus_b.tx;
      default: return bus_c.tx;
    endcase
  endfunction

  function automatic logic get_done(input int sel);
    case (sel)
      0:       return bus_a.done;
      1:       return bus_b.done;
      default: return bus_c.done;
    endcase
  endfunction

  function automatic int q_size(input int sel);
    case (sel)
      0:       return q_a.size();
      1:       return q_b.size();
      default: return q_c.size();
    endcase
  endfunction

  function automatic logic [7:0] q_pop(input int sel);
    case (sel)
      0:       return q_a.pop_front();
      1:       return q_b.pop_front();
      default: return q_c.pop_front();
    endcase
  endfunction

  task automatic set_start(input int sel, input logic v);
    case (sel)
      0:       bus_a.start = v;
      1:       bus_b.start = v;
      default: bus_c.start = v;
    endcase
  endtask

  // Returns at the negedge after the edge that sampled start (edge 0).
  task automatic pulse_start(input int sel);
    @(negedge clk);
    set_start(sel, 1'b1);
    @(negedge clk);
    set_start(sel, 1'b0);
  endtask

  task automatic wait_done(input int sel, input int k0, input int limit, output int at);
    at = -1;
    for (int k = k0 + 1; k <= limit && at < 0; k++) begin
      @(negedge clk);
      if (get_done(sel)) at = k;
    end
  endtask

  // UART receiver: samples mid-bit, pops the scoreboard on each full frame
  task automatic rx_mon(input int sel, input int div);
    logic [7:0] b;
    logic       stop_b;
    bit         aborted;
    forever begin
      @(negedge clk);
      if (!rst && get_tx(sel) == 1'b0) begin
        aborted = 0;
        repeat (div / 2) begin @(negedge clk); if (rst) aborted = 1; end
        for (int i = 0; i < 8; i++) begin
          repeat (div) begin @(negedge clk); if (rst) aborted = 1; end
          b[i] = get_tx(sel);
        end
        repeat (div) begin @(negedge clk); if (rst) aborted = 1; end
        stop_b = get_tx(sel);
        if (!aborted) begin
          if (q_size(sel) == 0) chk($sformatf("rx%0d_unexpected_byte", sel), {24'd0, b}, 32'hxx);
          else chk($sformatf("rx%0d_byte", sel), {24'd0, b}, {24'd0, q_pop(sel)});
          chk($sformatf("rx%0d_stop", sel), {31'd0, stop_b}, 32'd1);
        end
      end
    end
  endtask

  initial rx_mon(0, 4);
  initial rx_mon(1, 5);
  initial rx_mon(2, 2);

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int at, at2, cnt, done_cnt, tx_low, step_err, maxa, prev, a;
    logic lv[0:52];
    int exp_seq[10];

    vecs[0] = '{32'h12345678, 8'h12, 8'h34, 8'h56, 8'h78};
    vecs[1] = '{32'hA5A5A5A5, 8'hA5, 8'hA5, 8'hA5, 8'hA5};
    vecs[2] = '{32'hFFFFFFFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    vecs[3] = '{32'h00000000, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[4] = '{32'h80000001, 8'h80, 8'h00, 8'h00, 8'h01};
    vecs[5] = '{32'h0F1E2D3C, 8'h0F, 8'h1E, 8'h2D, 8'h3C};
    exp_seq = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

    rst = 1'b1;
    bus_a.start = 1'b0; bus_b.start = 1'b0; bus_c.start = 1'b0;
    bus_a.regData = 32'd0; bus_b.regData = 32'd0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_tx",      {31'd0, bus_a.tx},   32'd1);
    chk("rst_busy",    {31'd0, bus_a.busy}, 32'd0);
    chk("rst_done",    {31'd0, bus_a.done}, 32'd0);
    chk("rst_regaddr", {27'd0, bus_a.regAddr}, 32'd0);
    chk("rst_c_tx",    {31'd0, bus_c.tx},   32'd1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // single-register dumps from the vector table
    for (int v = 0; v < 6; v++) begin
      bus_a.regData = vecs[v].data;
      q_a.push_back(vecs[v].e0); q_a.push_back(vecs[v].e1);
      q_a.push_back(vecs[v].e2); q_a.push_back(vecs[v].e3);
      pulse_start(0);
      chk("busy_e0", {31'd0, bus_a.busy}, 32'd1);
      @(negedge clk);
      chk("tx_high_e1", {31'd0, bus_a.tx}, 32'd1);
      @(negedge clk);
      chk("tx_low_e2", {31'd0, bus_a.tx}, 32'd0);
      wait_done(0, 2, 400, at);
      chk("done_edge", at, 161);
      chk("busy_at_done", {31'd0, bus_a.busy}, 32'd0);
      @(negedge clk);
      chk("done_width", {31'd0, bus_a.done}, 32'd0);
      chk("sb_a_empty", q_size(0), 0);
      repeat (3) @(negedge clk);
    end

    // start in the done cycle launches an immediate second dump
    bus_a.regData = 32'h0BADF00D;
    repeat (2) begin
      q_a.push_back(8'h0B); q_a.push_back(8'hAD); q_a.push_back(8'hF0); q_a.push_back(8'h0D);
    end
    pulse_start(0);
    wait_done(0, 0, 400, at);
    chk("b2b_first_done", at, 161);
    bus_a.start = 1'b1;
    @(negedge clk);
    bus_a.start = 1'b0;
    chk("b2b_busy", {31'd0, bus_a.busy}, 32'd1);
    wait_done(0, 0, 400, at2);
    chk("b2b_second_done", at2, 161);
    @(negedge clk);
    chk("b2b_sb_empty", q_size(0), 0);

    // capture atomicity: regData changes during DATA of the only register
    bus_a.regData = 32'hDEADBEEF;
    q_a.push_back(8'hDE); q_a.push_back(8'hAD); q_a.push_back(8'hBE); q_a.push_back(8'hEF);
    pulse_start(0);
    repeat (20) @(negedge clk);
    bus_a.regData = 32'h11223344;
    wait_done(0, 20, 400, at);
    chk("atomic_done", at, 161);
    @(negedge clk);
    chk("atomic_sb_empty", q_size(0), 0);

    // reset mid-dump
    bus_a.regData = 32'hCAFEF00D;
    q_a.push_back(8'hCA); q_a.push_back(8'hFE); q_a.push_back(8'hF0); q_a.push_back(8'h0D);
    pulse_start(0);
    repeat (50) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_tx",      {31'd0, bus_a.tx},      32'd1);
    chk("mid_rst_busy",    {31'd0, bus_a.busy},    32'd0);
    chk("mid_rst_regaddr", {27'd0, bus_a.regAddr}, 32'd0);
    done_cnt = 0; tx_low = 0;
    repeat (2) begin @(negedge clk); if (bus_a.done) done_cnt++; end
    rst = 1'b0;
    q_a.delete();
    repeat (200) begin
      @(negedge clk);
      if (bus_a.done) done_cnt++;
      if (!bus_a.tx) tx_low++;
    end
    chk("mid_rst_no_done", done_cnt, 0);
    chk("mid_rst_tx_idle", tx_low, 0);
    chk("mid_rst_busy_after", {31'd0, bus_a.busy}, 32'd0);
    bus_a.regData = 32'h5A5AC3C3;
    q_a.push_back(8'h5A); q_a.push_back(8'h5A); q_a.push_back(8'hC3); q_a.push_back(8'hC3);
    pulse_start(0);
    wait_done(0, 0, 400, at);
    chk("restart_done", at, 161);
    @(negedge clk);
    chk("restart_sb_empty", q_size(0), 0);

    // bit timing at CLK_DIV=5, first byte 0xA5
    bus_b.regData = 32'hA5C33C5A;
    q_b.push_back(8'hA5); q_b.push_back(8'hC3); q_b.push_back(8'h3C); q_b.push_back(8'h5A);
    pulse_start(1);
    for (int k = 1; k <= 52; k++) begin
      @(negedge clk);
      lv[k] = bus_b.tx;
    end
    chk("bt_pre_start", {31'd0, lv[1]}, 32'd1);
    for (int j = 0; j < 10; j++) begin
      cnt = 0;
      for (int k = 2 + 5 * j; k <= 6 + 5 * j; k++)
        if (lv[k] == exp_seq[j][0]) cnt++;
      chk($sformatf("bt_level%0d", j), cnt, 5);
    end
    chk("bt_next_start", {31'd0, lv[52]}, 32'd0);
    wait_done(1, 52, 600, at);
    chk("bt_done", at, 201);
    @(negedge clk);
    chk("bt_sb_empty", q_size(1), 0);

    // full 32-register dump with extra starts while busy
    for (int n = 0; n < 32; n++)
      repeat (4) q_c.push_back(8'(n));
    pulse_start(2);
    done_cnt = 0; at = -1; prev = 0; step_err = 0; maxa = 0;
    for (int k = 0; k < 2700; k++) begin
      bus_c.start = (k == 100 || k == 1500);
      @(negedge clk);
      if (bus_c.done) begin
        done_cnt++;
        if (at < 0) at = k + 1;
      end
      a = int'(bus_c.regAddr);
      if (a != prev) begin
        if (!(a == prev + 1 || (a == 0 && prev == 31))) step_err++;
        prev = a;
      end
      if (a > maxa) maxa = a;
    end
    bus_c.start = 1'b0;
    chk("full_done_edge", at, 2592);
    chk("full_done_once", done_cnt, 1);
    chk("full_addr_steps", step_err, 0);
    chk("full_addr_max", maxa, 31);
    chk("full_addr_final", {27'd0, bus_c.regAddr}, 32'd0);
    chk("full_busy_final", {31'd0, bus_c.busy}, 32'd0);
    chk("full_sb_empty", q_size(2), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
